idex_stage: RTL and testbench

Pipeline register between ID and EX in the pipelined CPU, with integrated load-use hazard detection. It captures decoded register numbers, operands, immediate and control bits from ID, and presents them as the `IDEX_*` fields consumed by EX and the forwarding unit. When a load in EX is followed by a dependent instruction in ID, it inserts a one-cycle bubble and freezes PC and IF/ID. It also counts inserted bubbles for performance monitoring.

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/idex_stage_hazard_detect.sv | 25 ++
 rtl/idex_stage.sv | 129 ++++++++++++
 tb/tb_idex_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipelined CPU datapath.
// Holds the control bundle carried between stages and the ALU op classes.
package cpu_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_IMM   = 2'b11
  } aluop_e;

  typedef struct packed {
    logic   reg_write;
    logic   mem_to_reg;
    logic   mem_read;
    logic   mem_write;
    logic   alu_src;
    logic   reg_dst;
    aluop_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    reg_write:  1'b0,
    mem_to_reg: 1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    alu_src:    1'b0,
    reg_dst:    1'b0,
    alu_op:     ALUOP_ADD
  };

  // $0 never carries a real dependency, so it must never match.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != REG_ZERO) && (a == b);
  endfunction

endpackage

// File: rtl/idex_stage_hazard_detect.sv
// Load-use hazard compare between the load in ID/EX and the instruction in ID.
// Drives the PC / IF-ID write enables; hold freezes them but never raises the stall.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic       idex_mem_read,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       flush,
  input  logic       hold,
  output logic       load_use_stall,
  output logic       pc_write,
  output logic       ifid_write
);

  always_comb begin
    load_use_stall = idex_mem_read
                   && (reg_match(idex_rt, ifid_rs) || reg_match(idex_rt, ifid_rt))
                   && !flush;
    pc_write       = !(load_use_stall || hold);
    ifid_write     = pc_write;
  end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating
// bubble counter for performance monitoring.
module idex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  flush,
  input  logic [4:0]            IFID_Rs,
  input  logic [4:0]            IFID_Rt,
  input  logic [4:0]            IFID_Rd,
  input  logic [DATA_WIDTH-1:0] ID_ReadData1,
  input  logic [DATA_WIDTH-1:0] ID_ReadData2,
  input  logic [DATA_WIDTH-1:0] ID_Imm,
  input  logic                  ID_RegWrite,
  input  logic                  ID_MemtoReg,
  input  logic                  ID_MemRead,
  input  logic                  ID_MemWrite,
  input  logic                  ID_ALUSrc,
  input  logic                  ID_RegDst,
  input  logic [1:0]            ID_ALUOp,
  output logic [4:0]            IDEX_Rs,
  output logic [4:0]            IDEX_Rt,
  output logic [4:0]            IDEX_Rd,
  output logic [DATA_WIDTH-1:0] IDEX_ReadData1,
  output logic [DATA_WIDTH-1:0] IDEX_ReadData2,
  output logic [DATA_WIDTH-1:0] IDEX_Imm,
  output logic                  IDEX_RegWrite,
  output logic                  IDEX_MemtoReg,
  output logic                  IDEX_MemRead,
  output logic                  IDEX_MemWrite,
  output logic                  IDEX_ALUSrc,
  output logic                  IDEX_RegDst,
  output logic [1:0]            IDEX_ALUOp,
  output logic                  IDEX_Valid,
  output logic                  PCWrite,
  output logic                  IFID_Write,
  output logic                  load_use_stall,
  output logic [CNT_WIDTH-1:0]  bubble_count
);

  ctrl_t                 ctrl_q;
  ctrl_t                 id_ctrl;
  logic [4:0]            rs_q, rt_q, rd_q;
  logic [DATA_WIDTH-1:0] rd1_q, rd2_q, imm_q;
  logic                  valid_q;
  logic [CNT_WIDTH-1:0]  bubble_q;

  always_comb begin
    id_ctrl            = CTRL_NOP;
    id_ctrl.reg_write  = ID_RegWrite;
    id_ctrl.mem_to_reg = ID_MemtoReg;
    id_ctrl.mem_read   = ID_MemRead;
    id_ctrl.mem_write  = ID_MemWrite;
    id_ctrl.alu_src    = ID_ALUSrc;
    id_ctrl.reg_dst    = ID_RegDst;
    id_ctrl.alu_op     = aluop_e'(ID_ALUOp);
  end

  hazard_detect u_hazard (
    .idex_mem_read  (ctrl_q.mem_read),
    .idex_rt        (rt_q),
    .ifid_rs        (IFID_Rs),
    .ifid_rt        (IFID_Rt),
    .flush          (flush),
    .hold           (hold),
    .load_use_stall (load_use_stall),
    .pc_write       (PCWrite),
    .ifid_write     (IFID_Write)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q   <= CTRL_NOP;
      rs_q     <= REG_ZERO;
      rt_q     <= REG_ZERO;
      rd_q     <= REG_ZERO;
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
      valid_q  <= 1'b0;
      bubble_q <= '0;
    end else if (!hold) begin
      if (flush || load_use_stall) begin
        // Zeroed register numbers keep the bubble out of forwarding/hazard compares.
        ctrl_q  <= CTRL_NOP;
        rs_q    <= REG_ZERO;
        rt_q    <= REG_ZERO;
        rd_q    <= REG_ZERO;
        rd1_q   <= '0;
        rd2_q   <= '0;
        imm_q   <= '0;
        valid_q <= 1'b0;
        if (!(&bubble_q))
          bubble_q <= bubble_q + CNT_WIDTH'(1);
      end else begin
        ctrl_q  <= id_ctrl;
        rs_q    <= IFID_Rs;
        rt_q    <= IFID_Rt;
        rd_q    <= IFID_Rd;
        rd1_q   <= ID_ReadData1;
        rd2_q   <= ID_ReadData2;
        imm_q   <= ID_Imm;
        valid_q <= 1'b1;
      end
    end
  end

  assign IDEX_Rs        = rs_q;
  assign IDEX_Rt        = rt_q;
  assign IDEX_Rd        = rd_q;
  assign IDEX_ReadData1 = rd1_q;
  assign IDEX_ReadData2 = rd2_q;
  assign IDEX_Imm       = imm_q;
  assign IDEX_RegWrite  = ctrl_q.reg_write;
  assign IDEX_MemtoReg  = ctrl_q.mem_to_reg;
  assign IDEX_MemRead   = ctrl_q.mem_read;
  assign IDEX_MemWrite  = ctrl_q.mem_write;
  assign IDEX_ALUSrc    = ctrl_q.alu_src;
  assign IDEX_RegDst    = ctrl_q.reg_dst;
  assign IDEX_ALUOp     = ctrl_q.alu_op;
  assign IDEX_Valid     = valid_q;
  assign bubble_count   = bubble_q;

endmodule

// File: tb/tb_idex_stage.sv
// Bench for idex_stage: table of ID-side vectors with hand-derived stall flags,
// and a reference model whose next-state predictions are queued and compared after each edge.
module tb_idex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold, flush;
  logic [4:0]  ifid_rs, ifid_rt, ifid_rd;
  logic [31:0] id_rd1, id_rd2, id_imm;
  logic [7:0]  id_ctrl;  // {RegWrite,MemtoReg,MemRead,MemWrite,ALUSrc,RegDst,ALUOp[1:0]}

  logic [4:0]  x_rs, x_rt, x_rd;
  logic [31:0] x_rd1, x_rd2, x_imm;
  logic        x_rw, x_m2r, x_mr, x_mw, x_as, x_rdst, x_valid;
  logic [1:0]  x_aop;
  logic        pc_write, ifid_write, stall;
  logic [15:0] cnt;

  logic [4:0]  y_rs, y_rt, y_rd;
  logic [31:0] y_rd1, y_rd2, y_imm;
  logic        y_rw, y_m2r, y_mr, y_mw, y_as, y_rdst, y_valid;
  logic [1:0]  y_aop;
  logic        y_pcw, y_ifw, y_stall;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  idex_stage #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush),
    .IFID_Rs(ifid_rs), .IFID_Rt(ifid_rt), .IFID_Rd(ifid_rd),
    .ID_ReadData1(id_rd1), .ID_ReadData2(id_rd2), .ID_Imm(id_imm),
    .ID_RegWrite(id_ctrl[7]), .ID_MemtoReg(id_ctrl[6]), .ID_MemRead(id_ctrl[5]),
    .ID_MemWrite(id_ctrl[4]), .ID_ALUSrc(id_ctrl[3]), .ID_RegDst(id_ctrl[2]),
    .ID_ALUOp(id_ctrl[1:0]),
    .IDEX_Rs(x_rs), .IDEX_Rt(x_rt), .IDEX_Rd(x_rd),
    .IDEX_ReadData1(x_rd1), .IDEX_ReadData2(x_rd2), .IDEX_Imm(x_imm),
    .IDEX_RegWrite(x_rw), .IDEX_MemtoReg(x_m2r), .IDEX_MemRead(x_mr),
    .IDEX_MemWrite(x_mw), .IDEX_ALUSrc(x_as), .IDEX_RegDst(x_rdst),
    .IDEX_ALUOp(x_aop), .IDEX_Valid(x_valid),
    .PCWrite(pc_write), .IFID_Write(ifid_write),
    .load_use_stall(stall), .bubble_count(cnt)
  );

  idex_stage #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush),
    .IFID_Rs(ifid_rs), .IFID_Rt(ifid_rt), .IFID_Rd(ifid_rd),
    .ID_ReadData1(id_rd1), .ID_ReadData2(id_rd2), .ID_Imm(id_imm),
    .ID_RegWrite(id_ctrl[7]), .ID_MemtoReg(id_ctrl[6]), .ID_MemRead(id_ctrl[5]),
    .ID_MemWrite(id_ctrl[4]), .ID_ALUSrc(id_ctrl[3]), .ID_RegDst(id_ctrl[2]),
    .ID_ALUOp(id_ctrl[1:0]),
    .IDEX_Rs(y_rs), .IDEX_Rt(y_rt), .IDEX_Rd(y_rd),
    .IDEX_ReadData1(y_rd1), .IDEX_ReadData2(y_rd2), .IDEX_Imm(y_imm),
    .IDEX_RegWrite(y_rw), .IDEX_MemtoReg(y_m2r), .IDEX_MemRead(y_mr),
    .IDEX_MemWrite(y_mw), .IDEX_ALUSrc(y_as), .IDEX_RegDst(y_rdst),
    .IDEX_ALUOp(y_aop), .IDEX_Valid(y_valid),
    .PCWrite(y_pcw), .IFID_Write(y_ifw),
    .load_use_stall(y_stall), .bubble_count(cnt4)
  );

  typedef struct {
    logic        hold, flush;
    logic [4:0]  rs, rt, rd;
    logic [31:0] d1, d2, imm;
    logic [7:0]  ctrl;
    logic        exp_stall;
  } vec_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] d1, d2, imm;
    logic [7:0]  ctrl;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } state_t;

  localparam logic [7:0] C_ADD = 8'b1000_0110;
  localparam logic [7:0] C_LW  = 8'b1110_1000;
  localparam logic [7:0] C_SW  = 8'b0001_1000;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  state_t      m;
  state_t      sb[$];
  vec_t        vecs[$];

  function automatic state_t dut_state();
    state_t s;
    s.valid = x_valid; s.rs = x_rs; s.rt = x_rt; s.rd = x_rd;
    s.d1 = x_rd1; s.d2 = x_rd2; s.imm = x_imm;
    s.ctrl = {x_rw, x_m2r, x_mr, x_mw, x_as, x_rdst, x_aop};
    s.cnt = cnt; s.cnt4 = cnt4;
    return s;
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic h, input logic f, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [7:0] c, input logic es);
    vec_t v;
    v.hold = h; v.flush = f; v.rs = rs; v.rt = rt; v.rd = rd; v.ctrl = c; v.exp_stall = es;
    v.d1 = 32'h1000_0000 + 32'(rs) * 32'h11;
    v.d2 = 32'h2000_0000 + 32'(rt) * 32'h101;
    v.imm = {27'h7ff_fff0, rd};
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    logic   ms;
    state_t nx;
    @(negedge clk);
    hold = v.hold; flush = v.flush;
    ifid_rs = v.rs; ifid_rt = v.rt; ifid_rd = v.rd;
    id_rd1 = v.d1; id_rd2 = v.d2; id_imm = v.imm; id_ctrl = v.ctrl;
    #1;
    check({tag, ".stall"}, 160'(stall), 160'(v.exp_stall));
    check({tag, ".pcwrite"}, 160'(pc_write), 160'(!(v.exp_stall || v.hold)));
    check({tag, ".ifid_write"}, 160'(ifid_write), 160'(!(v.exp_stall || v.hold)));
    ms = m.ctrl[5] && (m.rt != 5'd0) && ((m.rt == v.rs) || (m.rt == v.rt)) && !v.flush;
    nx = m;
    if (!v.hold) begin
      if (v.flush || ms) begin
        nx = '0;
        nx.cnt  = (m.cnt == 16'hffff) ? m.cnt : m.cnt + 16'd1;
        nx.cnt4 = (m.cnt4 == 4'hf) ? m.cnt4 : m.cnt4 + 4'd1;
      end else begin
        nx.valid = 1'b1; nx.rs = v.rs; nx.rt = v.rt; nx.rd = v.rd;
        nx.d1 = v.d1; nx.d2 = v.d2; nx.imm = v.imm; nx.ctrl = v.ctrl;
      end
    end
    sb.push_back(nx);
    m = nx;
    @(posedge clk);
    #1;
    check({tag, ".regs"}, 160'(dut_state()), 160'(sb.pop_front()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; hold = 1'b0; flush = 1'b0;
    ifid_rs = '0; ifid_rt = '0; ifid_rd = '0;
    id_rd1 = '0; id_rd2 = '0; id_imm = '0; id_ctrl = '0;
    m = '0;
    #3;
    check("reset.regs", 160'(dut_state()), 160'(0));
    check("reset.pcwrite", 160'({pc_write, ifid_write, stall}), 160'(3'b110));
    @(negedge clk);
    reset = 1'b0;

    //          hold  flush rs     rt     rd     ctrl   stall
    vecs.push_back(mk(1'b0, 1'b0, 5'd1, 5'd2, 5'd3,  C_ADD, 1'b0)); // add $3,$1,$2
    vecs.push_back(mk(1'b0, 1'b0, 5'd9, 5'd8, 5'd0,  C_LW,  1'b0)); // lw $8
    vecs.push_back(mk(1'b0, 1'b0, 5'd8, 5'd4, 5'd10, C_ADD, 1'b1)); // uses $8 -> stall
    vecs.push_back(mk(1'b0, 1'b0, 5'd8, 5'd4, 5'd10, C_ADD, 1'b0)); // replay after bubble
    vecs.push_back(mk(1'b0, 1'b0, 5'd1, 5'd0, 5'd0,  C_LW,  1'b0)); // lw $0
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 5'd0, 5'd5,  C_ADD, 1'b0)); // $0 never stalls
    vecs.push_back(mk(1'b0, 1'b0, 5'd1, 5'd8, 5'd0,  C_SW,  1'b0)); // non-load rt=8
    vecs.push_back(mk(1'b0, 1'b0, 5'd3, 5'd8, 5'd6,  C_ADD, 1'b0)); // no false stall
    vecs.push_back(mk(1'b0, 1'b0, 5'd1, 5'd8, 5'd0,  C_LW,  1'b0)); // lw $8
    vecs.push_back(mk(1'b1, 1'b0, 5'd0, 5'd8, 5'd7,  C_ADD, 1'b1)); // hold x3
    vecs.push_back(mk(1'b1, 1'b0, 5'd8, 5'd2, 5'd9,  C_SW,  1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 5'd2, 5'd8, 5'd11, C_ADD, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 5'd8, 5'd1, 5'd12, C_ADD, 1'b1)); // bubble after hold
    vecs.push_back(mk(1'b0, 1'b0, 5'd8, 5'd7, 5'd0,  C_LW,  1'b0)); // lw $7
    vecs.push_back(mk(1'b0, 1'b1, 5'd7, 5'd2, 5'd13, C_ADD, 1'b0)); // flush beats hazard
    vecs.push_back(mk(1'b0, 1'b0, 5'd7, 5'd2, 5'd13, C_ADD, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 5'd1, 5'd8, 5'd0,  C_LW,  1'b0)); // lw $8 before reset
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted mid-cycle while a stall is pending.
    @(negedge clk);
    ifid_rs = 5'd8; ifid_rt = 5'd3; ifid_ctrl_nop();
    #1;
    check("midstall.pre_stall", 160'({stall, pc_write}), 160'(2'b10));
    #1 reset = 1'b1;
    #1;
    check("midstall.regs", 160'(dut_state()), 160'(0));
    check("midstall.flags", 160'({stall, pc_write, ifid_write}), 160'(3'b011));
    @(posedge clk);
    #1;
    check("midstall.after_edge", 160'(dut_state()), 160'(0));
    m = '0;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++)
      apply(mk(1'b0, 1'b1, 5'd8, 5'd8, 5'd1, C_LW, 1'b0), $sformatf("sat%0d", i));
    check("sat.cnt4", 160'(cnt4), 160'(4'd15));
    check("sat.cnt16", 160'(cnt), 160'(16'd20));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic ifid_ctrl_nop();
    hold = 1'b0; flush = 1'b0; id_ctrl = C_ADD;
  endtask

endmodule
